// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache with line refill and invalidate sweep.
// Lookups index from the next-fetch address; results return one cycle later.
module icache_fetch_responder #(
    parameter int FETCH_WIDTH = 2,
    parameter int LINE_WORDS  = 4,
    parameter int NUM_LINES   = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      icNextReadAddrIn,
    input  logic                       icRE,
    input  logic [ADDR_WIDTH-1:0]      icReadAddrIn,
    output logic [FETCH_WIDTH-1:0]     icReadHit,
    output logic [FETCH_WIDTH*32-1:0]  icReadDataOut,
    output logic                       icMissBusy,
    input  logic                       icFlushReq,
    output logic                       icFlushComplete,
    output logic                       memReq,
    output logic [ADDR_WIDTH-1:0]      memAddr,
    input  logic                       memReqAck,
    input  logic                       memRspValid,
    input  logic [LINE_WORDS*32-1:0]   memRspData
);
    localparam int OFFW  = $clog2(LINE_WORDS);
    localparam int IDXW  = $clog2(NUM_LINES);
    localparam int LOW   = 2 + OFFW;
    localparam int TLO   = LOW + IDXW;
    localparam int TAGW  = ADDR_WIDTH - TLO;
    localparam int LBITS = LINE_WORDS * 32;

    typedef enum logic [2:0] {
        S_SWEEP, S_IDLE, S_REQ, S_WAIT, S_WRITE
    } state_t;

    state_t state_q, state_d;
    logic [IDXW-1:0] sweep_q, sweep_d;
    logic pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] line_q, line_d;
    logic busy_q;
    logic [LBITS-1:0] rsp_q;

    logic [LBITS-1:0] data_mem [NUM_LINES];
    logic [TAGW-1:0]  tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_mem;

    logic [LBITS-1:0] data_q;
    logic [TAGW-1:0]  tag_q;
    logic             vld_q;
    logic [IDXW-1:0]  ridx_q;
    logic [IDXW-1:0]  rd_idx;

    logic [IDXW-1:0] miss_idx;
    logic [TAGW-1:0] miss_tag;
    logic [IDXW-1:0] nidx;
    logic [IDXW-1:0] ridx;
    logic [TAGW-1:0] rtag;
    logic [OFFW-1:0] roff;
    logic            lookup_ok;
    logic            unused_ok;

    assign miss_idx = line_q[TLO-1:LOW];
    assign miss_tag = line_q[ADDR_WIDTH-1:TLO];
    assign nidx     = icNextReadAddrIn[TLO-1:LOW];
    assign ridx     = icReadAddrIn[TLO-1:LOW];
    assign rtag     = icReadAddrIn[ADDR_WIDTH-1:TLO];
    assign roff     = icReadAddrIn[LOW-1:2];

    assign unused_ok = ^{icReadAddrIn[1:0],
                         icNextReadAddrIn[ADDR_WIDTH-1:TLO],
                         icNextReadAddrIn[LOW-1:0]};

    assign memReq          = (state_q == S_REQ);
    assign memAddr         = line_q;
    assign icMissBusy      = busy_q;
    assign icFlushComplete = (state_q == S_SWEEP) &&
                             (sweep_q == IDXW'(NUM_LINES - 1));

    // The read index register guards against a stale line after a redirect.
    assign lookup_ok = icRE && (state_q == S_IDLE) && vld_q &&
                       (tag_q == rtag) && (ridx_q == ridx);

    always_comb begin
        icReadHit     = '0;
        icReadDataOut = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (int'(roff) + i < LINE_WORDS) begin
                icReadHit[i] = lookup_ok;
                icReadDataOut[i*32 +: 32] =
                    data_q[(int'(roff) + i)*32 +: 32];
            end
        end
    end

    always_comb begin
        rd_idx = miss_idx;
        if (state_q == S_IDLE) begin
            rd_idx = nidx;
        end else if (state_q == S_SWEEP) begin
            rd_idx = sweep_q;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        pend_d  = pend_q;
        line_d  = line_q;
        unique case (state_q)
            S_SWEEP: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == IDXW'(NUM_LINES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (icFlushReq) begin
                    state_d = S_SWEEP;
                end else if (icRE && !icReadHit[0]) begin
                    line_d  = {icReadAddrIn[ADDR_WIDTH-1:LOW],
                               {LOW{1'b0}}};
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (memReqAck) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (memRspValid) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = (pend_q || icFlushReq) ? S_SWEEP : S_IDLE;
            end
            default: state_d = S_SWEEP;
        endcase
        if (icFlushReq && (state_q == S_REQ || state_q == S_WAIT ||
                           state_q == S_WRITE)) begin
            pend_d = 1'b1;
        end
        if (state_d == S_SWEEP) begin
            pend_d = 1'b0;
            if (state_q != S_SWEEP) begin
                sweep_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SWEEP;
            sweep_q <= '0;
            pend_q  <= 1'b0;
            line_q  <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            pend_q  <= pend_d;
            line_q  <= line_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_WAIT && memRspValid) begin
            rsp_q <= memRspData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == S_WRITE) begin
            data_mem[miss_idx] <= rsp_q;
            tag_mem[miss_idx]  <= miss_tag;
        end
        if (!rst && state_q == S_WRITE) begin
            valid_mem[miss_idx] <= 1'b1;
        end else if (!rst && state_q == S_SWEEP) begin
            valid_mem[sweep_q] <= 1'b0;
        end
    end

    // Write-first: refill and sweep cycles present the new contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            tag_q  <= '0;
            vld_q  <= 1'b0;
            ridx_q <= '0;
        end else begin
            ridx_q <= rd_idx;
            if (state_q == S_WRITE) begin
                data_q <= rsp_q;
                tag_q  <= miss_tag;
                vld_q  <= 1'b1;
            end else if (state_q == S_SWEEP) begin
                data_q <= '0;
                tag_q  <= tag_mem[rd_idx];
                vld_q  <= 1'b0;
            end else begin
                data_q <= data_mem[rd_idx];
                tag_q  <= tag_mem[rd_idx];
                vld_q  <= valid_mem[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed and randomized checks of the fetch cache against a line-level model.
module tb_icache_fetch_responder;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  icNextReadAddrIn;
    logic         icRE;
    logic [31:0]  icReadAddrIn;
    logic [1:0]   icReadHit;
    logic [63:0]  icReadDataOut;
    logic         icMissBusy;
    logic         icFlushReq;
    logic         icFlushComplete;
    logic         memReq;
    logic [31:0]  memAddr;
    logic         memReqAck;
    logic         memRspValid;
    logic [127:0] memRspData;

    int ntests = 0;
    int nfail  = 0;

    bit           mvalid [64];
    logic [21:0]  mtag   [64];
    logic [127:0] mdata  [64];

    always #5 clk = ~clk;

    icache_fetch_responder dut (
        .clk(clk),
        .rst(rst),
        .icNextReadAddrIn(icNextReadAddrIn),
        .icRE(icRE),
        .icReadAddrIn(icReadAddrIn),
        .icReadHit(icReadHit),
        .icReadDataOut(icReadDataOut),
        .icMissBusy(icMissBusy),
        .icFlushReq(icFlushReq),
        .icFlushComplete(icFlushComplete),
        .memReq(memReq),
        .memAddr(memAddr),
        .memReqAck(memReqAck),
        .memRspValid(memRspValid),
        .memRspData(memRspData)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    endtask

    // Current cycle must be the first sweep cycle.
    task automatic check_sweep(input string tag);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            chk({tag, "_busy"}, icMissBusy, 1);
            chk({tag, "_hit"}, icReadHit, 0);
            chk({tag, "_memreq"}, memReq, 0);
            chk({tag, "_done"}, icFlushComplete, (k == 63));
            tick();
            memRspValid = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_idle_busy"}, icMissBusy, 0);
        chk({tag, "_idle_done"}, icFlushComplete, 0);
        clear_model();
    endtask

    task automatic check_lanes(input string tag, input logic [31:0] a,
                               input bit hitl);
        logic [1:0] eh;
        int off;
        off = int'(a[3:2]);
        for (int i = 0; i < 2; i++) eh[i] = (off + i < 4) && hitl;
        chk({tag, "_hit"}, icReadHit, eh);
        for (int i = 0; i < 2; i++) begin
            if (off + i >= 4)
                chk({tag, "_lane_zero"}, icReadDataOut[i*32 +: 32], 0);
            else if (hitl)
                chk({tag, "_lane_data"}, icReadDataOut[i*32 +: 32],
                    mdata[a[9:4]][(off + i)*32 +: 32]);
        end
    endtask

    // mode: 0 plain, 1 flush pulse during WAIT, 2 reset during WAIT
    task automatic fetch(input logic [31:0] a, input logic [127:0] ln,
                         input int ad, input int rd, input int mode);
        logic [5:0]  ix;
        logic [21:0] tg;
        bit hitl;
        ix = a[9:4];
        tg = a[31:10];
        icRE = 1'b0;
        icNextReadAddrIn = a;
        tick();
        icReadAddrIn = a;
        icRE = 1'b1;
        @(negedge clk);
        hitl = mvalid[ix] && (mtag[ix] == tg);
        check_lanes("lookup", a, hitl);
        chk("lookup_busy", icMissBusy, 0);
        if (hitl) begin
            icRE = 1'b0;
            return;
        end
        tick();
        for (int k = 0; k < ad; k++) begin
            memRspValid = 1'($urandom);
            @(negedge clk);
            chk("req_wait_memreq", memReq, 1);
            chk("req_wait_hit", icReadHit, 0);
            tick();
        end
        memRspValid = 1'b0;
        memReqAck = 1'b1;
        @(negedge clk);
        chk("req_memreq", memReq, 1);
        chk("req_memaddr", memAddr, a & 32'hFFFF_FFF0);
        chk("req_busy", icMissBusy, 1);
        tick();
        memReqAck = 1'b0;
        if (mode == 1) icFlushReq = 1'b1;
        if (mode == 2) begin
            rst = 1'b1;
            @(negedge clk);
            chk("rstwait_memreq", memReq, 0);
            tick();
            rst = 1'b0;
            icRE = 1'b0;
            memRspValid = 1'b1;
            memRspData = ln;
            check_sweep("rst_sweep");
            return;
        end
        for (int k = 0; k < rd; k++) begin
            memReqAck = 1'($urandom);
            @(negedge clk);
            chk("wait_memreq", memReq, 0);
            chk("wait_hit", icReadHit, 0);
            chk("wait_busy", icMissBusy, 1);
            tick();
            icFlushReq = 1'b0;
        end
        memReqAck = 1'b0;
        memRspValid = 1'b1;
        memRspData = ln;
        @(negedge clk);
        chk("rsp_hit", icReadHit, 0);
        tick();
        icFlushReq = 1'b0;
        memRspValid = 1'b0;
        memRspData = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        chk("write_busy", icMissBusy, 1);
        chk("write_hit", icReadHit, 0);
        chk("write_memreq", memReq, 0);
        mvalid[ix] = 1'b1;
        mtag[ix] = tg;
        mdata[ix] = ln;
        if (mode == 1) begin
            icRE = 1'b0;
            tick();
            check_sweep("flush_sweep");
            return;
        end
        tick();
        @(negedge clk);
        check_lanes("refill", a, 1'b1);
        chk("refill_busy", icMissBusy, 0);
        icRE = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  a;
        logic [127:0] ln;
        int r;
        rst = 1'b1;
        icNextReadAddrIn = '0;
        icRE = 1'b0;
        icReadAddrIn = '0;
        icFlushReq = 1'b0;
        memReqAck = 1'b0;
        memRspValid = 1'b0;
        memRspData = '0;
        clear_model();
        tick();
        tick();
        @(negedge clk);
        chk("rst_memreq", memReq, 0);
        chk("rst_memaddr", memAddr, 0);
        chk("rst_hit", icReadHit, 0);
        chk("rst_data", icReadDataOut, 0);
        chk("rst_done", icFlushComplete, 0);
        chk("rst_busy", icMissBusy, 1);
        tick();
        rst = 1'b0;
        check_sweep("init_sweep");

        ln = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        fetch(32'h1000, ln, 0, 0, 0);
        fetch(32'h100C, ln, 0, 0, 0);
        fetch(32'h1004, ln, 0, 0, 0);
        fetch(32'h2000, {4{32'hB0B0_0000}}, 1, 1, 0);
        fetch(32'h1000, ln, 0, 0, 0);
        fetch(32'h3010, {4{32'hC0C0_0001}}, 0, 1, 1);
        fetch(32'h1000, ln, 0, 0, 0);
        fetch(32'h5020, {4{32'hD0D0_0002}}, 0, 0, 2);
        fetch(32'h1000, ln, 2, 0, 0);

        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 11));
            a = {22'($urandom_range(1, 3)), 6'($urandom_range(0, 3)),
                 2'($urandom), 2'($urandom)};
            ln = {$urandom, $urandom, $urandom, $urandom};
            if (r == 0) begin
                tick();
                icFlushReq = 1'b1;
                tick();
                icFlushReq = 1'b0;
                check_sweep("idle_flush");
            end else begin
                fetch(a, ln, int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), (r == 1) ? 1 : 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
